tensor_writer: RTL and testbench
================================

TENSOR_WRITER -- requirements
Module: tensor_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 9216, meaning the number of 32-bit words in the destination tensor_ram region.
REQ-002 The block SHALL have parameter D_WIDTH, default 32, meaning the write data width (4 int8 lanes).
REQ-003 The block SHALL have a port clk, input, width 1: the single clock; all state is rising-edge.
REQ-004 The block SHALL have a port reset, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have a port start, input, width 1: begins a tensor write pass when sampled high in IDLE.
REQ-006 The block SHALL have a port valid_in, input, width 1: byte_in holds a valid int8 result.
REQ-007 The block SHALL have a port byte_in, input, width 8 (int8_t): result byte from the compute datapath.
REQ-008 The block SHALL have a port last_in, input, width 1: qualifies byte_in as the final byte of the tensor.
REQ-009 The block SHALL have a port ready_out, output, width 1: the block accepts byte_in this cycle.
REQ-010 The block SHALL have a port we, output, width 1: write strobe to tensor_ram.
REQ-011 The block SHALL have a port addr_w, output, width $clog2(DEPTH): tensor_ram word address.
REQ-012 The block SHALL have a port din, output, width D_WIDTH: packed write word.
REQ-013 The block SHALL have a port busy, output, width 1: high in PACK and FLUSH.
REQ-014 The block SHALL have a port done, output, width 1: one-cycle pulse on pass completion.

Function
REQ-015 The FSM SHALL have states IDLE, PACK, FLUSH and DONE.
REQ-016 In IDLE, start=1 SHALL clear the word pointer and lane count to 0 and go to PACK next cycle; start in any other state SHALL be ignored.
REQ-017 A byte SHALL be accepted only on the cycle with valid_in=1 and ready_out=1.
REQ-018 ready_out SHALL be 1 only in PACK; accepted bytes SHALL NOT cause a stall, so back-to-back acceptance is sustained.
REQ-019 Packing SHALL be little-endian: lane k (k=0..3, in acceptance order) goes to din[8k+7:8k].
REQ-020 On the cycle the 4th lane is accepted, the next cycle SHALL present we=1 for exactly one cycle, with din = the packed word and addr_w = the current pointer; the lane count returns to 0.
REQ-021 The pointer SHALL increment by 1 after each write; all outputs SHALL be registered.
REQ-022 When last_in is accepted with fewer than 4 lanes filled, the FSM SHALL go to FLUSH, and the next cycle SHALL write the partial word with unfilled lanes zero, then go to DONE.
REQ-023 When last_in coincides with the 4th lane, the full word SHALL be written normally, then the FSM SHALL go to DONE.
REQ-024 When the write to addr_w=DEPTH-1 issues, the FSM SHALL go to DONE regardless of last_in, and further bytes SHALL NOT be accepted.
REQ-025 DONE SHALL last one cycle with done=1, ready_out=0, then the FSM SHALL return to IDLE.
REQ-026 The pointer SHALL never wrap past DEPTH-1.
REQ-027 In IDLE and DONE, we SHALL be 0.

Reset
REQ-028 When reset=0, the block SHALL immediately (asynchronously) force: state IDLE, we=0, addr_w=0, din=0, ready_out=0, busy=0, done=0, pointer=0, lane count=0, pack register=0.
REQ-029 Reset asserted mid-pass SHALL discard any partial word without writing it; after release, no write SHALL occur until a new start.

Verification
REQ-030 Full words: start, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44, we=1, addr_w=0, din=0x44332211.
REQ-031 Partial flush: bytes 0xAA,0xBB with last_in on 0xBB -> we=1, din=0x0000BBAA, then done=1 for one cycle.
REQ-032 Depth limit: with DEPTH=4, stream 16 bytes with no last_in -> writes at addresses 0..3 only, done pulses after address 3, ready_out=0 afterwards.
REQ-033 Backpressure and gaps: toggle valid_in randomly over 8 bytes -> exactly 2 writes with correct lane order; no write occurs while fewer than 4 lanes are filled.
REQ-034 Reset mid-pass: after 3 bytes accepted, pulse reset=0 -> all outputs 0 immediately; no write follows; a new start restarts at addr_w=0.
REQ-035 Start while busy: assert start during PACK -> pointer and lanes are unchanged, and the output stream is identical to the run without the extra start.

Source files
------------

// File: rtl/tensor_writer.sv
// Packs a stream of int8 results into little-endian D_WIDTH words and writes
// them to consecutive tensor_ram addresses, with a partial-word flush on last_in.
module tensor_writer #(
  parameter int unsigned DEPTH   = 9216,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       valid_in,
  input  logic [7:0]                 byte_in,
  input  logic                       last_in,
  output logic                       ready_out,
  output logic                       we,
  output logic [$clog2(DEPTH)-1:0]   addr_w,
  output logic [D_WIDTH-1:0]         din,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LANES = D_WIDTH / 8;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t               state;
  logic [AW-1:0]        ptr;
  logic [LW-1:0]        lane;
  logic [D_WIDTH-1:0]   pack;

  logic                 accept;
  logic                 full;
  logic                 at_end;
  logic [D_WIDTH-1:0]   merged;

  // Current byte merged into its lane; used both for the pack register and the write word.
  always_comb begin
    accept = ready_out && valid_in;
    full   = (lane == LW'(LANES - 1));
    at_end = (ptr == AW'(DEPTH - 1));
    merged = pack | (D_WIDTH'(byte_in) << {lane, 3'b000});
  end

  // The final write of a pass is presented during FLUSH so that DONE never carries we.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      lane      <= '0;
      pack      <= '0;
      we        <= 1'b0;
      addr_w    <= '0;
      din       <= '0;
      ready_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr       <= '0;
            lane      <= '0;
            pack      <= '0;
            state     <= PACK;
            ready_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PACK: begin
          if (accept) begin
            if (full || last_in) begin
              we     <= 1'b1;
              din    <= merged;
              addr_w <= ptr;
              lane   <= '0;
              pack   <= '0;
              if (!at_end) ptr <= ptr + AW'(1);
            end else begin
              lane <= lane + LW'(1);
              pack <= merged;
            end
            if (last_in || (full && at_end)) begin
              state     <= FLUSH;
              ready_out <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_writer.sv
// Directed bench for tensor_writer: packing order, flush, depth limit, gaps, reset and start-while-busy.
module tb_tensor_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          valid_in;
  logic [7:0]    byte_in;
  logic          last_in;
  logic          ready_out;
  logic          we;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];

  always #5 clk = ~clk;

  tensor_writer #(.DEPTH(DEPTH), .D_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .valid_in(valid_in), .byte_in(byte_in),
    .last_in(last_in), .ready_out(ready_out), .we(we), .addr_w(addr_w), .din(din),
    .busy(busy), .done(done)
  );

  // Write and done log, sampled mid-cycle
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr_w);
      wd.push_back(din);
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; valid_in = 1'b0; last_in = 1'b0; byte_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    wa.delete(); wd.delete(); done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    valid_in = 1'b1; byte_in = b; last_in = l;
    step();
    valid_in = 1'b0; last_in = 1'b0; byte_in = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we); end
    checks++; if (addr_w !== AW'(0)) begin errors++; $display("FAIL rst_addr: got %h want 0", addr_w); end
    checks++; if (din !== 32'h0) begin errors++; $display("FAIL rst_din: got %h want 0", din); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    reset = 1'b1;
    step();
    wa.delete(); wd.delete(); done_cnt = 0;
    // Bytes offered in IDLE without start must be ignored
    valid_in = 1'b1; byte_in = 8'h5A;
    step(); step(); step();
    idle_inputs();
    step();
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", ready_out); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL idle_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_full_word();
    do_reset();
    do_start();
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL full_ready: got %b want 1", ready_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL full_early_we: got %b want 0", we); end
    send(8'h44, 1'b0);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL full_we: got %b want 1", we); end
    checks++; if (addr_w !== AW'(0)) begin errors++; $display("FAIL full_addr: got %h want 0", addr_w); end
    checks++; if (din !== 32'h44332211) begin errors++; $display("FAIL full_din: got %h want 44332211", din); end
    step();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL full_we_pulse: got %b want 0", we); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %b want 1", ready_out); end
  endtask

  task automatic test_partial_flush();
    do_reset();
    do_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL flush_we: got %b want 1", we); end
    checks++; if (din !== 32'h0000BBAA) begin errors++; $display("FAIL flush_din: got %h want 0000bbaa", din); end
    checks++; if (addr_w !== AW'(0)) begin errors++; $display("FAIL flush_addr: got %h want 0", addr_w); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", ready_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_early: got %b want 0", done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_done: got %b want 1", done); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL flush_we_in_done: got %b want 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse: got %b want 0", done); end
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", wa.size()); end
  endtask

  task automatic test_depth_limit();
    logic [DW-1:0] exp_w [4];
    int idx;
    logic acc;
    exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    idx = 0;
    do_reset();
    do_start();
    for (int i = 0; i < 24; i++) begin
      valid_in = 1'b1; byte_in = 8'(idx + 1);
      acc = ready_out;
      step();
      if (acc) idx++;
    end
    idle_inputs();
    step();
    checks++; if (idx != 16) begin errors++; $display("FAIL depth_accepted: got %0d want 16", idx); end
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL depth_writes: got %0d want 4", wa.size()); end
    for (int k = 0; k < wa.size() && k < 4; k++) begin
      checks++; if (wa[k] !== AW'(k)) begin errors++; $display("FAIL depth_addr%0d: got %h want %h", k, wa[k], AW'(k)); end
      checks++; if (wd[k] !== exp_w[k]) begin errors++; $display("FAIL depth_din%0d: got %h want %h", k, wd[k], exp_w[k]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL depth_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != we_cyc + 1) begin errors++; $display("FAIL depth_done_time: got %0d want %0d", done_cyc, we_cyc + 1); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL depth_ready: got %b want 0", ready_out); end
  endtask

  task automatic test_backpressure();
    bit pat [14];
    int n;
    logic acc;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    n = 0;
    do_reset();
    do_start();
    for (int i = 0; i < 14; i++) begin
      if (pat[i]) begin valid_in = 1'b1; byte_in = 8'hA0 + 8'(n); end
      else begin valid_in = 1'b0; byte_in = 8'hEE; end
      acc = valid_in && ready_out;
      step();
      if (acc) n++;
    end
    idle_inputs();
    step(); step(); step(); step();
    checks++; if (n != 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", n); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL bp_writes: got %0d want 2", wa.size()); end
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== AW'(0) || wa[1] !== AW'(1)) begin errors++; $display("FAIL bp_addr: got %h,%h want 0,1", wa[0], wa[1]); end
      checks++; if (wd[0] !== 32'hA3A2A1A0) begin errors++; $display("FAIL bp_din0: got %h want a3a2a1a0", wd[0]); end
      checks++; if (wd[1] !== 32'hA7A6A5A4) begin errors++; $display("FAIL bp_din1: got %h want a7a6a5a4", wd[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
    send(8'hC0, 1'b0); send(8'hC1, 1'b0); send(8'hC2, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", we); end
    checks++; if (addr_w !== AW'(0)) begin errors++; $display("FAIL mid_addr: got %h want 0", addr_w); end
    checks++; if (din !== 32'h0) begin errors++; $display("FAIL mid_din: got %h want 0", din); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done); end
    step();
    reset = 1'b1;
    wa.delete(); wd.delete();
    valid_in = 1'b1; byte_in = 8'h77;
    for (int i = 0; i < 5; i++) step();
    idle_inputs();
    step();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL mid_no_write: got %0d want 0", wa.size()); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_idle_ready: got %b want 0", ready_out); end
    do_start();
    send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0); send(8'h54, 1'b0);
    step();
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL mid_restart_count: got %0d want 1", wa.size()); end
    if (wa.size() >= 1) begin
      checks++; if (wa[0] !== AW'(0)) begin errors++; $display("FAIL mid_restart_addr: got %h want 0", wa[0]); end
      checks++; if (wd[0] !== 32'h54535251) begin errors++; $display("FAIL mid_restart_din: got %h want 54535251", wd[0]); end
    end
  endtask

  task automatic test_start_busy();
    do_reset();
    do_start();
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    start = 1'b1;
    send(8'h03, 1'b0);
    start = 1'b0;
    send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b1);
    step(); step(); step();
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL sb_writes: got %0d want 2", wa.size()); end
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== AW'(0) || wa[1] !== AW'(1)) begin errors++; $display("FAIL sb_addr: got %h,%h want 0,1", wa[0], wa[1]); end
      checks++; if (wd[0] !== 32'h04030201) begin errors++; $display("FAIL sb_din0: got %h want 04030201", wd[0]); end
      checks++; if (wd[1] !== 32'h00000605) begin errors++; $display("FAIL sb_din1: got %h want 00000605", wd[1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL sb_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_flush();
    test_depth_limit();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
